// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline types for the forwarding/hazard unit:
// operand-select codes, FSM encoding and the shadow-stage record.
package fwd_hazard_ctrl_pkg;

    localparam int RA_W = 5;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;
    localparam logic [1:0] FWD_ZERO = 2'd3;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic [RA_W-1:0] rd;
    } stage_t;

endpackage

// File: rtl/fwd_sel_cmp.sv
// Per-operand forwarding priority comparator.
// The youngest in-flight producer wins; x0 and unused operands read the RF.
module fwd_sel_cmp
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic            use_rs,
    input  logic [RA_W-1:0] rs,
    input  stage_t          ex,
    input  stage_t          mem,
    output logic [1:0]      sel
);

    logic skip;
    logic ex_hit;
    logic mem_hit;

    assign skip    = !use_rs || (rs == '0);
    assign ex_hit  = !skip && ex.valid && ex.reg_write
                     && (rs == ex.rd);
    assign mem_hit = !skip && !ex_hit && mem.valid
                     && mem.reg_write && (rs == mem.rd);

    always_comb begin
        sel = FWD_RF;
        unique case (1'b1)
            ex_hit:  sel = FWD_MEM;
            mem_hit: sel = FWD_WB;
            default: sel = FWD_RF;
        endcase
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand-forwarding select generator with load-use stall detection.
// Keeps a shadow EX/MEM/WB pipeline of destination/write-enable bits.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_flush,
    output logic                  stall,
    output logic                  bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_count
);

    stage_t     id_s;
    stage_t     ex_q;
    stage_t     mem_q;
    stage_t     wb_q;
    state_t     state;
    logic       hz;
    logic       advance;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign id_s = '{
        valid:     1'b1,
        reg_write: id_reg_write,
        mem_read:  id_mem_read,
        rd:        id_rd
    };

    assign hz = id_valid && ex_q.valid && ex_q.mem_read
                && (ex_q.rd != '0)
                && ((id_use_rs1 && (id_rs1 == ex_q.rd))
                 || (id_use_rs2 && (id_rs2 == ex_q.rd)));

    // A flush kills the ID instruction, so it can never wait on a load.
    assign stall   = hz && !ex_flush;
    assign bubble  = stall;
    assign advance = id_valid && !stall && !ex_flush;

    fwd_sel_cmp u_cmp_a (
        .use_rs (id_use_rs1),
        .rs     (id_rs1),
        .ex     (ex_q),
        .mem    (mem_q),
        .sel    (sel_a)
    );

    fwd_sel_cmp u_cmp_b (
        .use_rs (id_use_rs2),
        .rs     (id_rs2),
        .ex     (ex_q),
        .mem    (mem_q),
        .sel    (sel_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            wb_q      <= mem_q;
            mem_q     <= ex_q;
            ex_q      <= advance ? id_s : '0;
            fwd_a_sel <= advance ? sel_a : FWD_RF;
            fwd_b_sel <= advance ? sel_b : FWD_RF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            stall_count <= '0;
        end else begin
            unique case (state)
                RUN:   state <= stall ? STALL : RUN;
                STALL: state <= RUN;
            endcase
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

    a_no_double_stall : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(stall && (state == STALL)));

    a_bubble_clean : assert property (
        @(posedge clk) disable iff (!rst_n)
        (wb_q.valid || (wb_q == '0)));

endmodule
